wb_decompressor: RTL and testbench

Responder end of the compressed wishbone link (cw bus). Sits on the far side of the 16-bit cw link, decodes the two-word header (header word, then low address word), and replays each request as a wishbone master cycle on the local bus, including 4- and 8-beat bursts. Write data is taken from `cw_io`, read data is returned on `cw_io`, and each beat is completed with a `cw_ack` pulse, or the transaction is aborted with `cw_err`.

---
 rtl/wb_decompressor_if.sv | 31 +++
 rtl/wb_decompressor.sv | 153 +++++++++++++++
 tb/tb_wb_decompressor.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_decompressor_if.sv
// Local-bus signal bundle for wb_decompressor: cw link strobes plus the wishbone master port.
// The 16-bit cw_io data lane stays a plain inout on the module because it is tri-stated.
interface wb_decompressor_if;
    logic        cw_req;
    logic        cw_dir;
    logic        cw_ack;
    logic        cw_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [23:0] wb_adr;
    logic [15:0] wb_o_dat;
    logic [1:0]  wb_sel;
    logic        wb_8_burst;
    logic        wb_4_burst;
    logic [15:0] wb_i_dat;
    logic        wb_ack;
    logic        wb_err;

    modport master (
        input  cw_req, cw_dir, wb_i_dat, wb_ack, wb_err,
        output cw_ack, cw_err, wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel,
               wb_8_burst, wb_4_burst
    );

    modport slave (
        output cw_req, cw_dir, wb_i_dat, wb_ack, wb_err,
        input  cw_ack, cw_err, wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel,
               wb_8_burst, wb_4_burst
    );
endinterface

// File: rtl/wb_decompressor.sv
// Responder end of the compressed wishbone link: decodes cw headers and replays them as
// wishbone master cycles. Define CW_TIMEOUT_EN to enable the 8-bit STB watchdog.
module wb_decompressor (
    input  logic              i_clk,
    input  logic              i_rst_n,
    inout  wire  [15:0]       cw_io,
    wb_decompressor_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StAdr, StAcpt, StLoad, StStb, StResp, StErr
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] base_q, base_d;
    logic [3:0]  type_q, type_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [2:0]  beat_q, beat_d;
    logic [23:0] adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdata_q, rdata_d;
    logic [2:0]  len_m1;
    logic        type_ok;

`ifdef CW_TIMEOUT_EN
    logic [7:0]  wdog_q, wdog_d;
`endif

    always_comb begin
        len_m1  = 3'd0;
        type_ok = 1'b1;
        case (type_q)
            4'b0000: len_m1 = 3'd0;
            4'b0001: len_m1 = 3'd7;
            4'b0010: len_m1 = 3'd3;
            default: type_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        type_d  = type_q;
        we_d    = we_q;
        sel_d   = sel_q;
        beat_d  = beat_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
`ifdef CW_TIMEOUT_EN
        wdog_d  = wdog_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Header words without the valid bit in [0] are not requests.
                if (bus.cw_req && cw_io[0]) begin
                    base_d[23:16] = cw_io[15:8];
                    type_d        = cw_io[7:4];
                    we_d          = cw_io[3];
                    sel_d         = cw_io[2:1];
                    state_d       = StAdr;
                end
            end
            StAdr: begin
                base_d[15:0] = cw_io;
                beat_d       = 3'd0;
                state_d      = type_ok ? StAcpt : StErr;
            end
            StAcpt: state_d = StLoad;
            StLoad: begin
                adr_d = base_q + {21'd0, beat_q};
                if (we_q) begin
                    wdat_d = cw_io;
                end
`ifdef CW_TIMEOUT_EN
                wdog_d = 8'd0;
`endif
                state_d = StStb;
            end
            StStb: begin
                if (bus.wb_err) begin
                    state_d = StErr;
                end else if (bus.wb_ack) begin
                    rdata_d = bus.wb_i_dat;
                    state_d = StResp;
                end
`ifdef CW_TIMEOUT_EN
                else if (wdog_q == 8'd254) begin
                    state_d = StErr;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            StResp: begin
                if (beat_q == len_m1) begin
                    state_d = StIdle;
                end else begin
                    beat_d  = beat_q + 3'd1;
                    state_d = StLoad;
                end
            end
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            type_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            beat_q  <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
`ifdef CW_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            type_q  <= type_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
`ifdef CW_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    // All link and bus strobes decode straight from the state register.
    assign bus.cw_ack     = (state_q == StAcpt) || (state_q == StResp);
    assign bus.cw_err     = (state_q == StErr);
    assign bus.wb_cyc     = (state_q == StLoad) || (state_q == StStb) || (state_q == StResp);
    assign bus.wb_stb     = (state_q == StStb);
    assign bus.wb_we      = we_q;
    assign bus.wb_sel     = sel_q;
    assign bus.wb_adr     = adr_q;
    assign bus.wb_o_dat   = wdat_q;
    assign bus.wb_8_burst = bus.wb_cyc && (type_q == 4'b0001);
    assign bus.wb_4_burst = bus.wb_cyc && (type_q == 4'b0010);

    assign cw_io = (state_q == StResp && !we_q && bus.cw_dir) ? rdata_q : 16'hzzzz;

endmodule

// File: tb/tb_wb_decompressor.sv
// Bench for wb_decompressor: a cw initiator task, a scoreboarded wishbone slave and
// cycle-latency checks against the documented protocol timing.
module tb_wb_decompressor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tb_oe = 1'b1;
    logic [15:0] tb_dat = 16'h0000;
    wire  [15:0] cw_io;

    wb_decompressor_if bus ();

    assign cw_io = tb_oe ? tb_dat : 16'hzzzz;

    wb_decompressor dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .cw_io   (cw_io),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] exp_adr[$];
    logic [15:0] exp_dat[$];
    logic        exp_we[$];
    logic [1:0]  exp_sel[$];
    logic [15:0] exp_rd[$];
    logic [1:0]  exp_burst = 2'b00;
    logic [15:0] wdat[8];

    int slv_wait = 0;
    int slv_err_beat = -1;
    int slv_beat = 0;
    int cyc_starts = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    logic cyc_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_fn(input logic [23:0] a);
        return a[15:0] ^ 16'h5A5A ^ {8'h00, a[23:16]};
    endfunction

    always @(negedge clk) begin
        if (bus.wb_cyc && !cyc_prev) cyc_starts++;
        cyc_prev = bus.wb_cyc;
        if (bus.cw_ack) ack_cnt++;
        if (bus.cw_err) err_cnt++;
    end

    // Wishbone slave: acks (or errs) after slv_wait wait states, checking each beat.
    initial begin
        int wcnt;
        logic [15:0] ed;
        logic ew;
        wcnt = 0;
        bus.wb_ack = 1'b0;
        bus.wb_err = 1'b0;
        bus.wb_i_dat = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.wb_ack || bus.wb_err) begin
                bus.wb_ack = 1'b0;
                bus.wb_err = 1'b0;
            end else if (bus.wb_cyc && bus.wb_stb) begin
                if (wcnt < slv_wait) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    if (exp_adr.size() == 0) begin
                        check_eq("wb_unexpected_beat", 32'(bus.wb_adr), 32'hFFFF_FFFF);
                    end else begin
                        check_eq("wb_adr", 32'(bus.wb_adr), 32'(exp_adr.pop_front()));
                        ew = exp_we.pop_front();
                        ed = exp_dat.pop_front();
                        check_eq("wb_we", 32'(bus.wb_we), 32'(ew));
                        check_eq("wb_sel", 32'(bus.wb_sel), 32'(exp_sel.pop_front()));
                        if (ew) check_eq("wb_o_dat", 32'(bus.wb_o_dat), 32'(ed));
                        check_eq("wb_burst", 32'({bus.wb_8_burst, bus.wb_4_burst}),
                                 32'(exp_burst));
                    end
                    if (slv_beat == slv_err_beat) begin
                        bus.wb_err = 1'b1;
                    end else begin
                        bus.wb_ack = 1'b1;
                        bus.wb_i_dat = rd_fn(bus.wb_adr);
                    end
                    slv_beat++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Initiator: sends header + low address, streams write data or checks read data.
    task automatic cw_txn(input logic [15:0] hdr, input logic [15:0] lo, input int nbeats,
                          input bit bad_type, output int n_ack, output bit got_err,
                          output int lat1, output int lat_last);
        logic        we;
        logic [23:0] base;
        int          cyc;
        bit          done;
        bit          saw_ack;
        we = hdr[3];
        base = {hdr[15:8], lo};
        slv_beat = 0;
        if (!bad_type) begin
            for (int b = 0; b < nbeats; b++) begin
                if (slv_err_beat >= 0 && b > slv_err_beat) break;
                exp_adr.push_back(base + 24'(b));
                exp_dat.push_back(we ? wdat[b] : 16'h0000);
                exp_we.push_back(we);
                exp_sel.push_back(hdr[2:1]);
                if (!we && b != slv_err_beat) exp_rd.push_back(rd_fn(base + 24'(b)));
            end
        end
        n_ack = 0;
        got_err = 1'b0;
        lat1 = 0;
        lat_last = 0;
        @(posedge clk); #1;
        tb_oe = 1'b1; tb_dat = hdr; bus.cw_req = 1'b1; bus.cw_dir = 1'b0;
        @(posedge clk); #1;
        bus.cw_req = 1'b0; tb_dat = lo;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            saw_ack = 1'b0;
            if (bus.cw_err) begin
                got_err = 1'b1;
                done = 1'b1;
                if (lat1 == 0) lat1 = cyc;
                lat_last = cyc;
            end else if (bus.cw_ack) begin
                if (lat1 == 0) lat1 = cyc;
                lat_last = cyc;
                if (n_ack > 0 && !we) begin
                    if (exp_rd.size() == 0) check_eq("rd_unexpected", 32'(cw_io), 32'hFFFF_FFFF);
                    else check_eq("cw_rd_data", 32'(cw_io), 32'(exp_rd.pop_front()));
                end
                n_ack++;
                saw_ack = 1'b1;
                if (n_ack == nbeats + 1) done = 1'b1;
            end
            @(posedge clk); #1;
            if (cyc == 1) begin
                if (we) tb_dat = wdat[0];
                else begin tb_oe = 1'b0; bus.cw_dir = 1'b1; end
            end
            if (saw_ack && we && n_ack >= 2 && n_ack - 1 < nbeats) tb_dat = wdat[n_ack-1];
        end
        if (!done) check_eq("txn_timeout", 32'(cyc), 32'd0);
        bus.cw_dir = 1'b0; tb_oe = 1'b1; tb_dat = 16'h0000;
    endtask

    initial begin
        int na, l1, ll, cs, ac, ec;
        bit ge;
        bit seen;
        bus.cw_req = 1'b0;
        bus.cw_dir = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_strobes", 32'({bus.cw_ack, bus.cw_err, bus.wb_cyc, bus.wb_stb, bus.wb_we}),
                 32'd0);
        check_eq("rst_sel_burst", 32'({bus.wb_sel, bus.wb_8_burst, bus.wb_4_burst}), 32'd0);
        check_eq("rst_adr", 32'(bus.wb_adr), 32'd0);
        check_eq("rst_dat", 32'(bus.wb_o_dat), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write, zero wait states.
        wdat[0] = 16'hBEEF; exp_burst = 2'b00; slv_wait = 0; cs = cyc_starts;
        cw_txn(16'h120D, 16'h3456, 1, 1'b0, na, ge, l1, ll);
        check_eq("sw_acks", na, 2);
        check_eq("sw_err", 32'(ge), 32'd0);
        check_eq("sw_acpt_lat", l1, 2);
        check_eq("sw_resp_lat", ll, 5);
        check_eq("sw_cyc_starts", cyc_starts - cs, 1);

        // 4-beat read across a 64K boundary, two wait states.
        exp_burst = 2'b01; slv_wait = 2; cs = cyc_starts;
        cw_txn(16'h0027, 16'hFFFE, 4, 1'b0, na, ge, l1, ll);
        check_eq("r4_acks", na, 5);
        check_eq("r4_err", 32'(ge), 32'd0);
        check_eq("r4_last_lat", ll, 22);
        check_eq("r4_cyc_starts", cyc_starts - cs, 1);

        // 8-beat write of 0..7.
        for (int i = 0; i < 8; i++) wdat[i] = 16'(i);
        exp_burst = 2'b10; slv_wait = 0; cs = cyc_starts; ac = ack_cnt;
        cw_txn(16'hA01F, 16'h0100, 8, 1'b0, na, ge, l1, ll);
        check_eq("w8_acks", na, 9);
        check_eq("w8_ack_pulses", ack_cnt - ac, 9);
        check_eq("w8_last_lat", ll, 26);
        check_eq("w8_cyc_starts", cyc_starts - cs, 1);

        // 8-beat read, slave errors on beat 2.
        exp_burst = 2'b10; slv_wait = 1; slv_err_beat = 2; ec = err_cnt;
        cw_txn(16'h3317, 16'h2000, 8, 1'b0, na, ge, l1, ll);
        check_eq("rerr_acks", na, 3);
        check_eq("rerr_got_err", 32'(ge), 32'd1);
        @(negedge clk);
        check_eq("rerr_pulse_1cyc", 32'({bus.cw_err, bus.wb_cyc}), 32'd0);
        check_eq("rerr_err_pulses", err_cnt - ec, 1);
        slv_err_beat = -1; slv_wait = 0;

        // Invalid cyc_type 0011: error straight after ADR, no bus cycle.
        cs = cyc_starts; exp_burst = 2'b00;
        cw_txn(16'h0031, 16'h0000, 1, 1'b1, na, ge, l1, ll);
        check_eq("bad_type_err", 32'(ge), 32'd1);
        check_eq("bad_type_acks", na, 0);
        check_eq("bad_type_lat", l1, 2);
        check_eq("bad_type_cyc", cyc_starts - cs, 0);

        // Request strobe without the valid bit is ignored.
        cs = cyc_starts; ac = ack_cnt; ec = err_cnt;
        @(posedge clk); #1;
        tb_dat = 16'h1200; bus.cw_req = 1'b1;
        @(posedge clk); #1;
        bus.cw_req = 1'b0; tb_dat = 16'h0000;
        repeat (6) @(posedge clk);
        check_eq("ign_req_activity", (cyc_starts - cs) + (ack_cnt - ac) + (err_cnt - ec), 0);

        // Back-to-back single read.
        cw_txn(16'h0001, 16'h0042, 1, 1'b0, na, ge, l1, ll);
        check_eq("sr_acks", na, 2);
        check_eq("sr_lat", ll, 5);

        // Reset asserted while a burst sits in STB.
        slv_wait = 100000; ac = ack_cnt; ec = err_cnt;
        @(posedge clk); #1;
        tb_dat = 16'hA01F; bus.cw_req = 1'b1;
        @(posedge clk); #1;
        bus.cw_req = 1'b0; tb_dat = 16'h0000;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.wb_stb) seen = 1'b1;
        end
        check_eq("rst_mid_stb_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_cyc_stb", 32'({bus.wb_cyc, bus.wb_stb}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        check_eq("rst_mid_acks", ack_cnt - ac, 1);
        check_eq("rst_mid_errs", err_cnt - ec, 0);
        slv_wait = 0;

`ifdef CW_TIMEOUT_EN
        // Slave never responds: watchdog aborts 255 cycles after STB entry.
        slv_wait = 100000; wdat[0] = 16'h1234; exp_burst = 2'b00;
        cw_txn(16'h000D, 16'h0010, 1, 1'b1, na, ge, l1, ll);
        check_eq("wdog_err", 32'(ge), 32'd1);
        check_eq("wdog_lat", ll, 259);
        slv_wait = 0;
`endif

        check_eq("sb_wb_drained", exp_adr.size(), 0);
        check_eq("sb_rd_drained", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
